// File: rtl/conv_seq_pkg.sv
// Shared constants for the 1x1 conv layer sequencer: FSM encoding, channel counts
// and the counter-width helper.
package conv_seq_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int N_IN  = 12;
  localparam int N_OUT = 6;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_seq_chk.sv
// Invariant checker for the sequencer's credit/FIFO relationship.
module conv_seq_chk #(
  parameter int CRD_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic             full,
  input logic [CRD_W-1:0] credits
);

  a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && full && !pop));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    credits <= CRD_W'(DEPTH));

endmodule

// File: rtl/conv_seq_fifo.sv
// First-word-fall-through synchronous FIFO for datapath results.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module conv_seq_fifo #(
  parameter int WIDTH = 192,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Head is forced to zero while empty so the output port is clean out of reset.
  assign rdata = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/conv1x1_layer_sequencer.sv
// Frame sequencer for the 12-in/6-out 1x1 conv datapath: credit-gated pixel feed,
// result FIFO and frame completion. `define CONV_SEQ_PERF_EN adds the stall_cnt output.
module conv1x1_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMG_Width  = 3,
  parameter int IMG_Height = 3,
  parameter int Datawidth  = 32,
  parameter int CONV_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [N_IN*Datawidth-1:0]  s_data,
  output logic                       conv_rst,
  output logic                       conv_valid_in,
  output logic [N_IN*Datawidth-1:0]  conv_data_in,
  input  logic                       conv_valid_out,
  input  logic [N_OUT*Datawidth-1:0] conv_data_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N_OUT*Datawidth-1:0] m_data
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int NPIX  = IMG_Width * IMG_Height;
  localparam int CNT_W = cnt_width(NPIX);
  localparam int CRD_W = cnt_width(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] NPIX_C  = CNT_W'(NPIX);
  localparam logic [CRD_W-1:0] DEPTH_C = CRD_W'(FIFO_DEPTH);

  if (CONV_LAT < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("conv1x1_layer_sequencer: CONV_LAT must be >=1, FIFO_DEPTH a power of 2 >=2");
  end

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;
  logic [CRD_W-1:0]          credits_q, credits_d;
  logic                      err_q, err_d;
  logic                      cvi_q, cvi_d;
  logic [N_IN*Datawidth-1:0] cdi_q, cdi_d;
  logic [1:0]                rst_sync_q;
  logic                      s_ready_c, accept, push, pop;
  logic                      fifo_empty, fifo_full;

  // Handshakes and FSM; counters only move on accept/push, so IDLE keeps them unless start clears.
  always_comb begin
    s_ready_c = (state_q == RUN) && (credits_q != {CRD_W{1'b0}}) && (in_cnt_q != NPIX_C);
    accept    = s_valid && s_ready_c;
    pop       = m_ready && !fifo_empty;
    push      = conv_valid_out && (state_q != IDLE) && (out_cnt_q != NPIX_C);
    state_d   = state_q;
    in_cnt_d  = accept ? (in_cnt_q + CNT_W'(1)) : in_cnt_q;
    out_cnt_d = push ? (out_cnt_q + CNT_W'(1)) : out_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          in_cnt_d  = {CNT_W{1'b0}};
          out_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept && (in_cnt_q == NPIX_C - CNT_W'(1))) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (out_cnt_q == NPIX_C) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Credits track in-flight plus stored results; a simultaneous accept and pop cancel out.
  always_comb begin
    case ({accept, pop})
      2'b10:   credits_d = credits_q - CRD_W'(1);
      2'b01:   credits_d = credits_q + CRD_W'(1);
      default: credits_d = credits_q;
    endcase
    err_d = err_q | (conv_valid_out && !push);
    cvi_d = accept;
    cdi_d = accept ? s_data : cdi_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= {CNT_W{1'b0}};
      out_cnt_q <= {CNT_W{1'b0}};
      credits_q <= DEPTH_C;
      err_q     <= 1'b0;
      cvi_q     <= 1'b0;
      cdi_q     <= {(N_IN*Datawidth){1'b0}};
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      cvi_q     <= cvi_d;
      cdi_q     <= cdi_d;
    end
  end

  // Datapath reset asserts with rst and releases on the second clock edge afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    if ((state_q == IDLE) && start) begin
      stall_d = 32'd0;
    end else if ((state_q == RUN) && s_valid && !s_ready_c && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

  conv_seq_fifo #(
    .WIDTH (N_OUT * Datawidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (conv_data_out),
    .pop   (pop),
    .rdata (m_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  conv_seq_chk #(
    .CRD_W (CRD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .full    (fifo_full),
    .credits (credits_q)
  );

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign s_ready       = s_ready_c;
  assign conv_rst      = rst_sync_q[1];
  assign conv_valid_in = cvi_q;
  assign conv_data_in  = cdi_q;
  assign m_valid       = !fifo_empty;

endmodule

// File: tb/tb_conv1x1_layer_sequencer.sv
// Directed bench for conv1x1_layer_sequencer with a 3-cycle behavioural datapath
// (Out_k = In_2k + In_2k+1) and a table of expected results per frame.
`timescale 1ns/1ps
module tb_conv1x1_layer_sequencer;

  localparam int DW   = 32;
  localparam int NIN  = 12;
  localparam int NOUT = 6;
  localparam int NPIX = 9;
  localparam int W    = NOUT * DW;

  typedef struct {
    int             frame;
    int             pix;
    logic [W-1:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, busy, done, err;
  logic             s_valid, s_ready, conv_rst, conv_valid_in, conv_valid_out;
  logic             m_valid, m_ready;
  logic [NIN*DW-1:0] s_data, conv_data_in;
  logic [W-1:0]     conv_data_out, m_data;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0]      stall_cnt;
`endif

  conv1x1_layer_sequencer #(
    .IMG_Width (3), .IMG_Height (3), .Datawidth (DW), .CONV_LAT (3), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .busy (busy), .done (done), .err (err),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
    .conv_rst (conv_rst), .conv_valid_in (conv_valid_in), .conv_data_in (conv_data_in),
    .conv_valid_out (conv_valid_out), .conv_data_out (conv_data_out),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data)
`ifdef CONV_SEQ_PERF_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [NIN*DW-1:0] pix_data(input int f, input int p);
    logic [NIN*DW-1:0] r;
    for (int c = 0; c < NIN; c++) r[c*DW +: DW] = DW'(f*256 + p*16 + c);
    return r;
  endfunction

  function automatic logic [W-1:0] pair_sum(input logic [NIN*DW-1:0] a);
    logic [W-1:0] r;
    for (int k = 0; k < NOUT; k++) r[k*DW +: DW] = a[2*k*DW +: DW] + a[(2*k+1)*DW +: DW];
    return r;
  endfunction

  // Upstream source: pixel index advances on each handshake.
  int   frame_id;
  int   src_idx;
  logic src_clr;
  always @(posedge clk) begin
    if (src_clr) src_idx <= 0;
    else if (s_valid && s_ready) src_idx <= src_idx + 1;
  end
  assign s_data = pix_data(frame_id, src_idx);

  // Behavioural datapath, flushed by conv_rst; inj_v forces a stray valid_out.
  logic [2:0]   pv;
  logic [W-1:0] pd [3];
  logic         inj_v;
  logic [W-1:0] inj_d;
  always @(posedge clk) begin
    if (conv_rst) pv <= 3'b000;
    else pv <= {pv[1:0], conv_valid_in};
    pd[0] <= pair_sum(conv_data_in);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
  end
  assign conv_valid_out = pv[2] | inj_v;
  assign conv_data_out  = inj_v ? inj_d : pd[2];

  int           cyc;
  logic         mon_clr;
  logic [W-1:0] got_q [$];
  int           cvi_cyc [$];
  int           cvo_cyc [$];
  int           stall_ref;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clr) begin
      got_q.delete();
      cvi_cyc.delete();
      cvo_cyc.delete();
      stall_ref <= 0;
    end else begin
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (conv_valid_in) cvi_cyc.push_back(cyc);
      if (conv_valid_out && !inj_v) cvo_cyc.push_back(cyc);
      if (busy && s_valid && !s_ready && (src_idx < NPIX)) stall_ref <= stall_ref + 1;
    end
  end

  int   checks, errors;
  int   done_cyc, start_cyc;
  vec_t vecs [4*NPIX];
  int   cvi_exp [NPIX];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int f);
    frame_id = f;
    src_clr  = 1'b1;
    mon_clr  = 1'b1;
    tick();
    src_clr  = 1'b0;
    mon_clr  = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: done not seen within %0d cycles", tag, budget);
    end else begin
      done_cyc = cyc;
      check({tag, "_busy_at_done"}, busy, 1);
      tick();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_fall"}, busy, 0);
    end
  endtask

  task automatic check_frame(input int f, input string tag);
    check({tag, "_count"}, got_q.size(), NPIX);
    for (int i = 0; i < NPIX; i++) begin
      if (i < got_q.size()) check($sformatf("%s_res%0d", tag, i), got_q[i], vecs[f*NPIX+i].exp);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    inj_v = 1'b0; inj_d = {6{32'hDEAD_BEEF}}; frame_id = 0;
    src_clr = 1'b1; mon_clr = 1'b1;
    checks = 0; errors = 0;
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < NPIX; p++) begin
        vecs[f*NPIX+p].frame = f;
        vecs[f*NPIX+p].pix   = p;
        for (int k = 0; k < NOUT; k++)
          vecs[f*NPIX+p].exp[k*DW +: DW] = DW'(f*512 + p*32 + 4*k + 1);
      end
    end
    // 4 credits against a 5-edge accept->pop round trip: bursts of 4, then credit-paced.
    cvi_exp = '{0, 1, 2, 3, 6, 7, 8, 9, 12};

    // Reset state
    s_valid = 1'b1;
    tick(); tick();
    check("rst_conv_rst", conv_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cvi", conv_valid_in, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b1;
    tick();
    check("conv_rst_edge1", conv_rst, 1);
    tick();
    check("conv_rst_edge2", conv_rst, 0);
    check("idle_s_ready", s_ready, 0);
    s_valid = 1'b0;

    // Full-throughput frame
    m_ready = 1'b1; s_valid = 1'b1;
    start_frame(0);
    wait_done(80, "f0");
    s_valid = 1'b0;
    repeat (4) tick();
    check_frame(0, "f0");
    check("f0_cvi_count", cvi_cyc.size(), NPIX);
    if (cvi_cyc.size() == NPIX) begin
      check("f0_first_cvi_lat", cvi_cyc[0] - start_cyc, 1);
      for (int i = 1; i < NPIX; i++)
        check($sformatf("f0_cvi_off%0d", i), cvi_cyc[i] - cvi_cyc[0], cvi_exp[i]);
    end
    if (cvo_cyc.size() == NPIX) check("f0_done_lat", done_cyc - cvo_cyc[NPIX-1], 2);
    else check("f0_cvo_count", cvo_cyc.size(), NPIX);

    // Back-pressure: credits cap acceptance at FIFO depth
    m_ready = 1'b0; s_valid = 1'b1;
    start_frame(1);
    repeat (15) tick();
    check("bp_accepted4", src_idx, 4);
    check("bp_s_ready_low", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    repeat (10) tick();
    check("bp_accepted5", src_idx, 5);
    check("bp_s_ready_low2", s_ready, 0);
    check("bp_err", err, 0);
    m_ready = 1'b1;
    wait_done(120, "f1");
    s_valid = 1'b0;
    repeat (4) tick();
    check_frame(1, "f1");
    check("f1_err", err, 0);
`ifdef CONV_SEQ_PERF_EN
    check("perf_stall_cnt", stall_cnt, stall_ref);
`endif

    // Stray datapath output while idle
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    check("stray_err", err, 1);
    check("stray_fifo_empty", m_valid, 0);
    repeat (5) tick();
    check("stray_err_sticky", err, 1);

    // Reset mid-frame, then a clean frame
    s_valid = 1'b1; m_ready = 1'b1;
    start_frame(2);
`ifdef CONV_SEQ_PERF_EN
    check("perf_start_clears", stall_cnt, 0);
`endif
    check("restart_busy", busy, 1);
    for (int n = 0; n < 40 && src_idx < 5; n++) tick();
    check("midrst_reached_px5", src_idx, 5);
    rst = 1'b0;
    #1;
    check("midrst_conv_rst", conv_rst, 1);
    check("midrst_busy", busy, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_err_cleared", err, 0);
    tick();
    rst = 1'b1;
    m_ready = 1'b0;
    tick(); tick();
    check("midrst_conv_rst_rel", conv_rst, 0);
    start_frame(3);
    repeat (15) tick();
    check("post_rst_credits4", src_idx, 4);
    m_ready = 1'b1;
    wait_done(120, "f3");
    s_valid = 1'b0;
    repeat (10) tick();
    check_frame(3, "f3");
    check("f3_err", err, 0);
    check("f3_fifo_empty", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
